// File: rtl/hap_pkg.sv
// Shared definitions for the Harvard processor front end: opcode constants,
// the fetch state encoding and the branch-opcode classifier. The branch stage
// imports the same package, so both stages agree on which opcodes redirect the PC.
package hap_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_BNE  = 5'b10011;
    localparam logic [OP_W-1:0] OP_BE   = 5'b10100;
    localparam logic [OP_W-1:0] OP_BNER = 5'b10101;
    localparam logic [OP_W-1:0] OP_BER  = 5'b10110;
    localparam logic [OP_W-1:0] OP_J    = 5'b10111;
    localparam logic [OP_W-1:0] OP_JR   = 5'b11000;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11111;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // Branch-class opcodes form one contiguous range, BNE through JR.
    function automatic logic is_branch(input logic [OP_W-1:0] op);
        return (op >= OP_BNE) && (op <= OP_JR);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and the branch stage.
//
// Handshake semantics:
//   Memory side: imem_req/imem_addr are held stable until a cycle in which
//   imem_req=1 and imem_ack=1; imem_data is captured on that edge. imem_ack
//   with imem_req=0 is ignored.
//   Downstream side: data/NPC are held stable while valid=1 and ready=0; the
//   instruction is consumed on an edge where valid=1 and ready=1, and PC must
//   be valid on that same edge. ready with valid=0 has no effect.
interface fetch_unit_if #(
    parameter int PC_W = 8,
    parameter int IW   = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [IW-1:0]   imem_data;
    logic [IW-1:0]   data;
    logic [PC_W-1:0] NPC;
    logic            valid;
    logic            ready;
    logic [PC_W-1:0] PC;

    modport master (
        output imem_req, imem_addr, data, NPC, valid,
        input  imem_ack, imem_data, ready, PC
    );

    modport slave (
        input  imem_req, imem_addr, data, NPC, valid,
        output imem_ack, imem_data, ready, PC
    );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with its fall-through incrementer and the
// next-PC select between the fall-through and the branch-stage target.
module pc_reg #(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            take_pc,
    input  logic [PC_W-1:0] pc_in,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] npc
);
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Fall-through wraps modulo 2**PC_W with no carry-out.
    assign npc = pc_q + PC_W'(1);
    assign pc  = pc_q;

    // Next PC: branch target only for branch-class opcodes, else fall-through.
    always_comb begin
        pc_d = pc_q;
        if (advance) begin
            pc_d = take_pc ? pc_in : npc;
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RST_PC;
        end else begin
            pc_q <= pc_d;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: requests a word at pc, latches it for the branch
// stage, then advances pc from NPC or the branch stage's resolved PC.
// Optional feature macro: FETCH_HALT_EN (opcode 5'b11111 stops fetching and
// adds the halted output).
module fetch_unit
    import hap_pkg::*;
#(
    parameter int              PC_W   = 8,
    parameter int              IW     = 16,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus,
`ifdef FETCH_HALT_EN
    output logic          halted,
`endif
    output fetch_state_e  dbg_state
);
    fetch_state_e    state_q, state_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic [IW-1:0]   data_q, data_d;
    logic            advance;
    logic [OP_W-1:0] op;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] npc;
`ifdef FETCH_HALT_EN
    logic            halted_q, halted_d;
`endif

    assign op = data_q[IW-1 -: OP_W];

    pc_reg #(
        .PC_W   (PC_W),
        .RST_PC (RST_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .take_pc (is_branch(op)),
        .pc_in   (bus.PC),
        .pc      (pc),
        .npc     (npc)
    );

    // Next-state and registered-output logic of the fetch FSM. req_q stays low
    // in the first REQ cycle after reset so the request starts one cycle late.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        valid_d = valid_q;
        data_d  = data_q;
        advance = 1'b0;
`ifdef FETCH_HALT_EN
        halted_d = halted_q;
`endif
        case (state_q)
            REQ: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (bus.imem_ack) begin
                    data_d  = bus.imem_data;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.ready) begin
                    advance = 1'b1;
                    valid_d = 1'b0;
`ifdef FETCH_HALT_EN
                    if (op == OP_HALT) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                    end
`else
                    state_d = REQ;
                    req_d   = 1'b1;
`endif
                end
            end
            HALT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = REQ;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef FETCH_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            data_q  <= data_d;
`ifdef FETCH_HALT_EN
            halted_q <= halted_d;
`endif
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = pc;
    assign bus.data      = data_q;
    assign bus.NPC       = npc;
    assign bus.valid     = valid_q;
    assign dbg_state     = state_q;
`ifdef FETCH_HALT_EN
    assign halted        = halted_q;
`endif
endmodule
